fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, issues instruction reads to the icache, and writes the F/D latch fields (`instr`, `pc_plus_4`) that decode consumes. It handles hazard-unit stalls, branch/jump redirects resolved downstream, and a fetch-side halt state so the core stops issuing reads once a HALT has been fetched.

---
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the five-stage pipeline. Owns the program
//   counter, issues icache reads, and writes the F/D latch consumed by decode.
//   Handles hazard stalls, downstream redirects, and stops issuing reads once
//   a HALT instruction has been fetched.
//
// Parameters
//   PC_INIT      PC value loaded on reset
//   HALT_OP      opcode (instr[31:26]) identifying HALT
//
// Ports
//   CLK          core clock, rising edge
//   RST          synchronous active-high reset
//   imemREN      icache read request
//   imemaddr     icache read address (always the current pc)
//   ihit         icache hit, imemload valid this cycle
//   imemload     instruction word from the icache
//   stall        hazard unit hold of pc and F/D latch
//   redirect     taken branch/jump resolved downstream
//   redirect_pc  target pc for redirect
//   fd_instr     F/D latch instruction field
//   fd_pc_plus_4 F/D latch pc+4 field
//   fd_valid     F/D latch holds a real instruction (0 = bubble)
//   fetch_halted fetch is in the HALTED state
//   fetch_count  number of instructions accepted into F/D (wraps)
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc_plus_4,
    output logic        fd_valid,
    output logic        fetch_halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;

    assign pc_next_seq  = pc + 32'd4;
    assign imemaddr     = pc;
    // Request is gated by RST so no read is issued while reset is held.
    assign imemREN      = (state == FETCH) && !RST;
    assign fetch_halted = (state == HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc           <= PC_INIT;
            fd_instr     <= '0;
            fd_pc_plus_4 <= '0;
            fd_valid     <= 1'b0;
            fetch_count  <= '0;
            state        <= FETCH;
        end else if (redirect) begin
            // Redirect overrides stall and cancels any wrong-path HALT.
            pc           <= redirect_pc;
            fd_instr     <= '0;
            fd_pc_plus_4 <= '0;
            fd_valid     <= 1'b0;
            state        <= FETCH;
        end else if (stall) begin
            // Hold everything, including a valid F/D entry during a miss.
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        fd_instr     <= imemload;
                        fd_pc_plus_4 <= pc_next_seq;
                        fd_valid     <= 1'b1;
                        fetch_count  <= fetch_count + 32'd1;
                        if (imemload[31:26] == HALT_OP) begin
                            // pc stays on the HALT so nothing past it is fetched.
                            state <= HALTED;
                        end else begin
                            pc <= pc_next_seq;
                        end
                    end else begin
                        fd_instr     <= '0;
                        fd_pc_plus_4 <= '0;
                        fd_valid     <= 1'b0;
                    end
                end
                HALTED: begin
                    fd_instr     <= '0;
                    fd_pc_plus_4 <= '0;
                    fd_valid     <= 1'b0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc_plus_4;
    logic        fd_valid;
    logic        fetch_halted;
    logic [31:0] fetch_count;

    // Second instance exercising pc wrap at the top of the address space.
    logic        rst2;
    logic        imem_ren2;
    logic [31:0] imem_addr2;
    logic        ihit2;
    logic [31:0] imem_load2;
    logic [31:0] fd_instr2;
    logic [31:0] fd_pc_plus_42;
    logic        fd_valid2;
    logic        fetch_halted2;
    logic [31:0] fetch_count2;

    int unsigned applied;
    int unsigned miscompares;

    fetch_stage #(.PC_INIT(32'h0000_0000), .HALT_OP(6'b111111)) dut (
        .CLK(clk), .RST(rst), .imemREN(imem_ren), .imemaddr(imem_addr),
        .ihit(ihit), .imemload(imem_load), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fd_instr(fd_instr), .fd_pc_plus_4(fd_pc_plus_4), .fd_valid(fd_valid),
        .fetch_halted(fetch_halted), .fetch_count(fetch_count)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC), .HALT_OP(6'b111111)) dut_wrap (
        .CLK(clk), .RST(rst2), .imemREN(imem_ren2), .imemaddr(imem_addr2),
        .ihit(ihit2), .imemload(imem_load2), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .fd_instr(fd_instr2), .fd_pc_plus_4(fd_pc_plus_42), .fd_valid(fd_valid2),
        .fetch_halted(fetch_halted2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        ihit;
        logic [31:0] load;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic h, logic [31:0] ld, logic s,
                                logic rd, logic [31:0] rp, logic en,
                                logic [31:0] ad, logic [31:0] ins,
                                logic [31:0] p4, logic v, logic hl,
                                logic [31:0] c);
        vec_t t;
        t.rst = r; t.ihit = h; t.load = ld; t.stall = s; t.redir = rd;
        t.rpc = rp; t.ren = en; t.addr = ad; t.instr = ins; t.pp4 = p4;
        t.valid = v; t.halted = hl; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
            miscompares++;
        end
    endtask

    initial begin
        applied = 0;
        miscompares = 0;
        rst = 1'b1; ihit = 1'b0; imem_load = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        rst2 = 1'b1; ihit2 = 1'b0; imem_load2 = '0;

        //              rst hit load          stl rdr rpc          ren addr          instr         pp4           v  h  cnt
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'd0)); // reset
        vecs.push_back(mk(0, 1, 32'h2001_0005, 0, 0, 32'h0,        1, 32'h0000_0004, 32'h2001_0005, 32'h4,        1, 0, 32'd1));
        vecs.push_back(mk(0, 1, 32'h2002_0007, 0, 0, 32'h0,        1, 32'h0000_0008, 32'h2002_0007, 32'h8,        1, 0, 32'd2));
        vecs.push_back(mk(0, 1, 32'h0,        0, 0, 32'h0,        1, 32'h0000_000C, 32'h0,        32'hC,        1, 0, 32'd3));
        vecs.push_back(mk(0, 1, 32'h8C00_0000, 0, 0, 32'h0,        1, 32'h0000_0010, 32'h8C00_0000, 32'hC + 4,    1, 0, 32'd4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0010, 32'h0,        32'h0,        0, 0, 32'd4)); // miss x3
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0010, 32'h0,        32'h0,        0, 0, 32'd4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0010, 32'h0,        32'h0,        0, 0, 32'd4));
        vecs.push_back(mk(0, 1, 32'h0100_0020, 0, 0, 32'h0,        1, 32'h0000_0014, 32'h0100_0020, 32'h14,       1, 0, 32'd5));
        vecs.push_back(mk(0, 1, 32'hAAAA_AAAA, 1, 0, 32'h0,        1, 32'h0000_0014, 32'h0100_0020, 32'h14,       1, 0, 32'd5)); // stall x2
        vecs.push_back(mk(0, 1, 32'hAAAA_AAAA, 1, 0, 32'h0,        1, 32'h0000_0014, 32'h0100_0020, 32'h14,       1, 0, 32'd5));
        vecs.push_back(mk(0, 1, 32'h0200_0030, 0, 0, 32'h0,        1, 32'h0000_0018, 32'h0200_0030, 32'h18,       1, 0, 32'd6));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0000_0018, 32'h0200_0030, 32'h18,       1, 0, 32'd6)); // stall+miss
        vecs.push_back(mk(0, 1, 32'h5555_5555, 1, 1, 32'h40,       1, 32'h0000_0040, 32'h0,        32'h0,        0, 0, 32'd6)); // redirect+stall
        vecs.push_back(mk(0, 1, 32'h0300_0040, 0, 0, 32'h0,        1, 32'h0000_0044, 32'h0300_0040, 32'h44,       1, 0, 32'd7));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h20,       1, 32'h0000_0020, 32'h0,        32'h0,        0, 0, 32'd7));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,        0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h24,       1, 1, 32'd8)); // HALT
        vecs.push_back(mk(0, 1, 32'h1111_1111, 0, 0, 32'h0,        0, 32'h0000_0020, 32'h0,        32'h0,        0, 1, 32'd8));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h80,       1, 32'h0000_0080, 32'h0,        32'h0,        0, 0, 32'd8)); // leave HALTED
        vecs.push_back(mk(0, 1, 32'hFC00_0000, 0, 1, 32'h100,      1, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 32'd8)); // redirect beats HALT
        vecs.push_back(mk(0, 1, 32'h0400_0000, 0, 0, 32'h0,        1, 32'h0000_0104, 32'h0400_0000, 32'h104,      1, 0, 32'd9));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0104, 32'h0,        32'h0,        0, 0, 32'd9));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'd0)); // reset mid-miss
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,        0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h4,        1, 1, 32'd1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'd0)); // reset mid-HALTED
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; ihit = vecs[i].ihit; imem_load = vecs[i].load;
            stall = vecs[i].stall; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            applied++;
            chk("imemREN",      i, {31'b0, imem_ren},     {31'b0, vecs[i].ren});
            chk("imemaddr",     i, imem_addr,             vecs[i].addr);
            chk("fd_instr",     i, fd_instr,              vecs[i].instr);
            chk("fd_pc_plus_4", i, fd_pc_plus_4,          vecs[i].pp4);
            chk("fd_valid",     i, {31'b0, fd_valid},     {31'b0, vecs[i].valid});
            chk("fetch_halted", i, {31'b0, fetch_halted}, {31'b0, vecs[i].halted});
            chk("fetch_count",  i, fetch_count,           vecs[i].cnt);
        end

        // fetch_count wrap: preload all-ones, one hit must roll it to zero.
        @(negedge clk);
        ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        @(negedge clk);
        ihit = 1'b1; imem_load = 32'h0500_0000;
        @(posedge clk);
        #1;
        applied++;
        chk("count_wrap",      100, fetch_count,  32'h0);
        chk("count_wrap_pp4",  100, fd_pc_plus_4, 32'h4);
        @(negedge clk);
        ihit = 1'b0;

        // pc wrap on the high-PC_INIT instance.
        @(posedge clk);
        #1;
        applied++;
        chk("wrap_reset_addr", 200, imem_addr2,             32'hFFFF_FFFC);
        chk("wrap_reset_ren",  200, {31'b0, imem_ren2},     32'h0);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("wrap_start_ren",  201, {31'b0, imem_ren2},     32'h1);
        chk("wrap_start_addr", 201, imem_addr2,             32'hFFFF_FFFC);
        ihit2 = 1'b1; imem_load2 = 32'h2001_0005;
        @(posedge clk);
        #1;
        applied++;
        chk("wrap_pp4",        202, fd_pc_plus_42,          32'h0);
        chk("wrap_addr",       202, imem_addr2,             32'h0);
        chk("wrap_valid",      202, {31'b0, fd_valid2},     32'h1);
        chk("wrap_instr",      202, fd_instr2,              32'h2001_0005);
        chk("wrap_count",      202, fetch_count2,           32'h1);
        @(negedge clk);
        ihit2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
